seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed driver for DIGITS common-anode seven-segment digits. Replaces per-digit combinational decoding with one shared decoder, a refresh prescaler, and a digit scan counter. Sits between the datapath, which presents a packed nibble vector, and the board segment and anode pins. Adds display modes, frame-coherent snapshotting, and optional leading-zero blanking.

## Interface
- DIGITS, default 4: number of scanned digits; legal range 2..8.
- DIV, default 100000: clk cycles per digit slot; minimum 2.
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- value  input  4*DIGITS  packed nibbles; digit k = value[4k+3:4k], digit 0 rightmost.
- dp_in  input  DIGITS  decimal-point request per digit, 1 = lit.
- mode  input  2  00 hex, 01 BCD, 10 lamp test, 11 blank.
- seg  output  7  {g,f,e,d,c,b,a}, active-low (0 = segment on).
- dp  output  1  decimal point, active-low.
- an  output  DIGITS  digit enables, active-low, at most one low at a time.
- frame_done  output  1  one-cycle pulse after the last digit slot of each frame.

## Operation
- Prescaler `cnt` has width $clog2(DIV).
  - It increments every clk.
  - At cnt == DIV-1 it returns to 0 and raises internal `tick` for that cycle.
- Scan index `idx` has width $clog2(DIGITS) and advances on `tick`.
  - DIGITS-1 wraps to 0; there is no other wrap value.
- Shadow register `shv` and `shdp` capture `value` and `dp_in` on the `tick` that wraps idx to 0.
  - A whole frame therefore shows one coherent snapshot.
  - Input changes mid-frame appear only at the next frame.
- The decoder maps nibble n = shv[4*idx+3 -: 4]:
  - 0..9, A..F use the standard active-low glyphs: 0→1000000, 1→1111001, … 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Mode behaviour:
  - 00: full hex glyphs.
  - 01: n ≤ 9 uses the normal glyph; n > 9 shows dash 0111111.
  - 10: seg = 0000000, dp = 0, all digits still scanned in turn. Lamp test ignores the snapshot.
  - 11: an all 1, seg 1111111, dp 1. Scanning and frame_done continue.
- dp = ~shdp[idx] in modes 00 and 01.
- `mode` is sampled every cycle, not snapshotted, so a mode change takes effect one cycle later.

## Timing
- Reset values:
  - cnt = 0, idx = 0, shv = 0, shdp = 0.
  - seg = 1111111, dp = 1, an = all 1, frame_done = 0.
- seg, dp, an and frame_done are registered.
  - They reflect idx and mode with one cycle of latency.
  - The first cycle after reset release drives digit 0 with glyph 0 (shv = 0).
- Digit changeover:
  - Slot k lasts exactly DIV cycles.
  - an switches one cycle after the `tick` cycle.
  - an never has two bits low in the same cycle.
- frame_done is high for exactly one cycle: the cycle after the wrapping `tick`, aligned with an switching to digit 0.
- Frame period is DIGITS*DIV cycles.
- Reset asserted mid-frame:
  - All state returns immediately to reset values.
  - No partial frame_done is emitted.
- A `value` change on the same cycle as the wrapping tick is captured (sampled on that edge).

## Configuration
- Macro: SEG7_SCAN_LZB_EN.
- When defined, leading-zero blanking applies in modes 00 and 01:
  - Digit k ≥ 1 is blanked (an bit held 1, seg 1111111, dp 1) when shv nibbles k..DIGITS-1 are all zero and shdp[k] = 0.
  - Digit 0 is never blanked.
  - The blanked slot still consumes DIV cycles, so scan period and brightness are unchanged.
- When undefined, every digit is always displayed, including leading zeros. No LZB logic is synthesised.

## Test plan
Bench uses DIGITS=4, DIV=4.
- **Reset and first slot:** hold rst=0 for 3 cycles → seg=1111111, an=1111, dp=1. Release → next cycle an=1110, seg=1000000. After 4 cycles an=1101.
- **Snapshot and hex decode:** value=16'h12AF, dp_in=4'b0100, mode=00 after one frame → slots show F 0001110, A 0001000, 2 0100100 with dp=0, 1 1111001. A value change mid-frame is not shown until after the next frame_done.
- **BCD and lamp test:** mode=01 with value=16'h9A05 → slots 5, 0, dash 0111111, 9. mode=10 → seg=0000000, dp=0 in every slot. mode=11 → an=1111 while frame_done still pulses every 16 cycles.
- **Frame pulse:** run 5 frames → exactly 5 single-cycle frame_done pulses spaced 16 cycles apart, each coincident with an=1110. Assert rst mid-frame → no pulse and outputs at reset values.
- **LZB (macro defined):** value=16'h0030, dp_in=0 → digits 2 and 3 blank (an bits stay 1 in their slots), digits 1 and 0 show 3 and 0. Macro undefined → digits 3 and 2 show 1000000.
- **Glitch rule:** across all runs, assert an never has more than one bit low in any cycle.

Source files
------------

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed common-anode seven-segment scanner.
// Optional leading-zero blanking: define SEG7_SCAN_LZB_EN.
module seg7_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [1:0]            mode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shv_q;
  logic [DIGITS-1:0]   shdp_q;
  logic                wrap_q;
  logic                tick, wrap, blank_lz;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   an_scan;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   an_d;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

`ifdef SEG7_SCAN_LZB_EN
  logic [DIGITS-1:0] lz_blank;
  logic              hi_zero;

  // A digit is blanked only if it and every more-significant nibble are zero.
  always_comb begin
    hi_zero  = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero     = hi_zero & (shv_q[4*k +: 4] == 4'd0);
      lz_blank[k] = hi_zero & ~shdp_q[k];
    end
  end
  assign blank_lz = lz_blank[idx_q];
`else
  assign blank_lz = 1'b0;
`endif

  assign nib     = shv_q[{idx_q, 2'b00} +: 4];
  assign an_scan = ~(DIGITS'(1) << idx_q);

  always_comb begin
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    an_d  = '1;
    case (mode)
      2'b10: begin
        seg_d = 7'b0000000;
        dp_d  = 1'b0;
        an_d  = an_scan;
      end
      2'b11: ;
      default: begin
        if (!blank_lz) begin
          if (mode == 2'b01 && nib > 4'd9) seg_d = 7'b0111111;
          else                             seg_d = hex_glyph(nib);
          dp_d = ~shdp_q[idx_q];
          an_d = an_scan;
        end
      end
    endcase
  end

  // frame_done trails the wrapping tick by one cycle so it lines up with digit 0's enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shv_q      <= '0;
      shdp_q     <= '0;
      wrap_q     <= 1'b0;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wrap_q     <= wrap;
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_done <= wrap_q;
      if (wrap) begin
        shv_q  <= value;
        shdp_q <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan (DIGITS=4, DIV=4).
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [1:0]  mode;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int vectors;
  int miscompares;
  bit run_mon;

  seg7_scan #(.DIGITS(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .mode(mode),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (run_mon) begin
      vectors++;
      if ($countones(~an) > 1) begin
        $display("FAIL an_onehot: an=%b has more than one low bit", an);
        miscompares++;
      end
    end
  end

  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    vectors++;
    if (!frame_done) begin
      $display("FAIL sync_timeout: frame_done=%b after %0d cycles, required 1", frame_done, n);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an5;
    logic [6:0] exp_seg5;
    rst = 1'b0; value = '0; dp_in = '0; mode = 2'b00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({seg, dp, an, frame_done} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
      $display("FAIL reset_outputs: seg=%b dp=%b an=%b fd=%b, required 1111111 1 1111 0", seg, dp, an, frame_done);
      miscompares++;
    end
    rst = 1'b1;
    @(negedge clk);
    run_mon = 1'b1;
    vectors++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      $display("FAIL first_slot: an=%b seg=%b dp=%b, required 1110 1000000 1", an, seg, dp);
      miscompares++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (an !== 4'b1110) begin
      $display("FAIL slot0_len: an=%b, required 1110", an);
      miscompares++;
    end
    @(negedge clk);
`ifdef SEG7_SCAN_LZB_EN
    exp_an5 = 4'b1111; exp_seg5 = 7'b1111111;
`else
    exp_an5 = 4'b1101; exp_seg5 = 7'b1000000;
`endif
    vectors++;
    if ({an, seg} !== {exp_an5, exp_seg5}) begin
      $display("FAIL slot1_start: an=%b seg=%b, required %b %b", an, seg, exp_an5, exp_seg5);
      miscompares++;
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    logic       exp_dp  [4];
    exp_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    value = 16'h12AF; dp_in = 4'b0100; mode = 2'b00;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({an, seg, dp} !== {exp_an[k], exp_seg[k], exp_dp[k]}) begin
        $display("FAIL hex_slot%0d: an=%b seg=%b dp=%b, required %b %b %b", k, an, seg, dp, exp_an[k], exp_seg[k], exp_dp[k]);
        miscompares++;
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_snapshot();
    sync_frame();
    repeat (4) @(negedge clk);
    value = 16'h3456;
    repeat (4) @(negedge clk);
    vectors++;
    if ({an, seg} !== {4'b1011, 7'b0100100}) begin
      $display("FAIL snap_slot2: an=%b seg=%b, required 1011 0100100", an, seg);
      miscompares++;
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({an, seg} !== {4'b0111, 7'b1111001}) begin
      $display("FAIL snap_slot3: an=%b seg=%b, required 0111 1111001", an, seg);
      miscompares++;
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({frame_done, an, seg} !== {1'b1, 4'b1110, 7'b0000010}) begin
      $display("FAIL snap_next: fd=%b an=%b seg=%b, required 1 1110 0000010", frame_done, an, seg);
      miscompares++;
    end
  endtask

  task automatic test_bcd_lamp();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    exp_seg = '{7'b0010010, 7'b1000000, 7'b0111111, 7'b0010000};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    value = 16'h9A05; dp_in = 4'b0000; mode = 2'b01;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({an, seg, dp} !== {exp_an[k], exp_seg[k], 1'b1}) begin
        $display("FAIL bcd_slot%0d: an=%b seg=%b dp=%b, required %b %b 1", k, an, seg, dp, exp_an[k], exp_seg[k]);
        miscompares++;
      end
      repeat (4) @(negedge clk);
    end
    mode = 2'b10;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({an, seg, dp} !== {exp_an[k], 7'b0000000, 1'b0}) begin
        $display("FAIL lamp_slot%0d: an=%b seg=%b dp=%b, required %b 0000000 0", k, an, seg, dp, exp_an[k]);
        miscompares++;
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_blank();
    int n;
    bit lit;
    mode = 2'b11;
    sync_frame();
    vectors++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      $display("FAIL blank_out: an=%b seg=%b dp=%b, required 1111 1111111 1", an, seg, dp);
      miscompares++;
    end
    n = 0; lit = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (an !== 4'b1111) lit = 1'b1;
    end while (!frame_done && n < 40);
    vectors++;
    if (n != 16 || lit) begin
      $display("FAIL blank_period: period=%0d lit=%b, required 16 0", n, lit);
      miscompares++;
    end
  endtask

  task automatic test_frame_pulse();
    int n;
    mode = 2'b00; value = 16'h12AF; dp_in = '0;
    sync_frame();
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      vectors++;
      if (frame_done !== 1'b0) begin
        $display("FAIL pulse%0d_width: fd=%b one cycle after pulse, required 0", p, frame_done);
        miscompares++;
      end
      n = 1;
      while (!frame_done && n < 40) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (n != 16 || an !== 4'b1110) begin
        $display("FAIL pulse%0d_spacing: spacing=%0d an=%b, required 16 1110", p, n, an);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit pulsed;
    sync_frame();
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({seg, dp, an, frame_done} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
      $display("FAIL midrst_outputs: seg=%b dp=%b an=%b fd=%b, required 1111111 1 1111 0", seg, dp, an, frame_done);
      miscompares++;
    end
    pulsed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done !== 1'b0) pulsed = 1'b1;
    end
    vectors++;
    if (pulsed) begin
      $display("FAIL midrst_pulse: frame_done rose during reset, required none");
      miscompares++;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({an, seg, frame_done} !== {4'b1110, 7'b1000000, 1'b0}) begin
      $display("FAIL midrst_first: an=%b seg=%b fd=%b, required 1110 1000000 0", an, seg, frame_done);
      miscompares++;
    end
    n = 1;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 17) begin
      $display("FAIL midrst_frame: first pulse at cycle %0d, required 17", n);
      miscompares++;
    end
  endtask

  task automatic test_lzb();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    value = 16'h0030; dp_in = 4'b0000; mode = 2'b00;
`ifdef SEG7_SCAN_LZB_EN
    exp_seg = '{7'b1000000, 7'b0110000, 7'b1111111, 7'b1111111};
    exp_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
    exp_seg = '{7'b1000000, 7'b0110000, 7'b1000000, 7'b1000000};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({an, seg, dp} !== {exp_an[k], exp_seg[k], 1'b1}) begin
        $display("FAIL lzb_slot%0d: an=%b seg=%b dp=%b, required %b %b 1", k, an, seg, dp, exp_an[k], exp_seg[k]);
        miscompares++;
      end
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; run_mon = 1'b0;
    test_reset();
    test_hex();
    test_snapshot();
    test_bcd_lamp();
    test_blank();
    test_frame_pulse();
    test_reset_mid();
    test_lzb();
    run_mon = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
